// File: rtl/riscv_mc_control_if.sv
// ---------------------------------------------------------------------------
// riscv_mc_control_if : datapath <-> multi-cycle control bundle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface riscv_mc_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       i_opcode;
  logic             i_branch_taken;
  logic             i_mem_ready;
  logic             o_pc_write;
  logic             o_ir_write;
  logic             o_mem_read;
  logic             o_mem_write;
  logic             o_reg_write;
  logic [1:0]       o_alu_src_a;
  logic [1:0]       o_alu_src_b;
  logic [1:0]       o_alu_op;
  logic [1:0]       o_mem_to_reg;
  logic [1:0]       o_pc_src;
  logic [3:0]       o_state;
  logic             o_instr_retired;
  logic [CNT_W-1:0] o_instret;
  logic             o_trap;
  logic [1:0]       o_trap_cause;

  modport master (
    output i_opcode, i_branch_taken, i_mem_ready,
    input  o_pc_write, o_ir_write, o_mem_read, o_mem_write, o_reg_write,
    input  o_alu_src_a, o_alu_src_b, o_alu_op, o_mem_to_reg, o_pc_src,
    input  o_state, o_instr_retired, o_instret, o_trap, o_trap_cause
  );

  modport slave (
    input  i_opcode, i_branch_taken, i_mem_ready,
    output o_pc_write, o_ir_write, o_mem_read, o_mem_write, o_reg_write,
    output o_alu_src_a, o_alu_src_b, o_alu_op, o_mem_to_reg, o_pc_src,
    output o_state, o_instr_retired, o_instret, o_trap, o_trap_cause
  );
endinterface

`default_nettype wire

// File: rtl/riscv_mc_control.sv
// ---------------------------------------------------------------------------
// riscv_mc_control : multi-cycle RISC-V control FSM with instret/traps. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_mc_control #(
  parameter int CNT_W       = 32,
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic         clk,
  input  wire logic         reset,
  riscv_mc_control_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam int unsigned     C_TO_LAST_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [TO_W-1:0] c_to_last   = TO_W'(C_TO_LAST_I);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_instret;
  logic [TO_W-1:0]  r_wait_cnt;
  logic             r_trap;
  logic [1:0]       r_trap_cause;

  logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
  logic [1:0] w_src_a, w_src_b, w_alu_op, w_mem_to_reg, w_pc_src, w_cause;
  logic       w_retire, w_to_hit, w_is_wait;

  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A mem_ready arriving on the final allowed cycle suppresses the timeout.
  assign w_to_hit  = (MEM_TIMEOUT != 0) && w_is_wait && (r_wait_cnt == c_to_last) &&
                     !bus.i_mem_ready;

  always_comb begin
    w_next       = r_state;
    w_cause      = 2'b00;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_alu_op     = 2'b00;
    w_mem_to_reg = 2'b00;
    w_pc_src     = 2'b00;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_src_b    = 2'b01;
        w_pc_write = bus.i_mem_ready;
        w_ir_write = bus.i_mem_ready;
        if (bus.i_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_src_a = 2'b10;
        w_src_b = 2'b10;
        case (bus.i_opcode)
          7'b0110011:             w_next = S_EXEC_R;
          7'b0010011:             w_next = S_EXEC_I;
          7'b0000011, 7'b0100011: w_next = S_ADDR;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          7'b1100111:             w_next = S_JALR;
          default: begin
            w_next  = S_TRAP;
            w_cause = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        w_src_a  = 2'b01;
        w_alu_op = 2'b10;
        w_next   = S_WB_ALU;
      end
      S_EXEC_I: begin
        w_src_a  = 2'b01;
        w_src_b  = 2'b10;
        w_alu_op = 2'b11;
        w_next   = S_WB_ALU;
      end
      S_ADDR: begin
        w_src_a = 2'b01;
        w_src_b = 2'b10;
        w_next  = (bus.i_opcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        if (bus.i_mem_ready) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        if (bus.i_mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b01;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_BRANCH: begin
        w_src_a    = 2'b01;
        w_alu_op   = 2'b01;
        w_pc_src   = 2'b01;
        w_pc_write = bus.i_branch_taken;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_JAL: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b10;
        w_pc_src     = 2'b01;
        w_pc_write   = 1'b1;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_JALR: begin
        w_src_a      = 2'b01;
        w_src_b      = 2'b10;
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b10;
        w_pc_src     = 2'b10;
        w_pc_write   = 1'b1;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_TRAP: w_next = S_TRAP;
      default: begin
        w_next  = S_TRAP;
        w_cause = 2'b01;
      end
    endcase
    if (w_to_hit) begin
      w_next  = S_TRAP;
      w_cause = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_instret    <= '0;
      r_wait_cnt   <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
      // The counter only survives while parked in the same wait state.
      if (w_next != r_state || bus.i_mem_ready) r_wait_cnt <= '0;
      else if (w_is_wait)                       r_wait_cnt <= r_wait_cnt + TO_W'(1);
      if (w_next == S_TRAP && r_state != S_TRAP) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_cause;
      end
    end
  end

  assign bus.o_pc_write      = w_pc_write  & ~reset;
  assign bus.o_ir_write      = w_ir_write  & ~reset;
  assign bus.o_reg_write     = w_reg_write & ~reset;
  assign bus.o_mem_write     = w_mem_write & ~reset;
  assign bus.o_mem_read      = w_mem_read;
  assign bus.o_alu_src_a     = w_src_a;
  assign bus.o_alu_src_b     = w_src_b;
  assign bus.o_alu_op        = w_alu_op;
  assign bus.o_mem_to_reg    = w_mem_to_reg;
  assign bus.o_pc_src        = w_pc_src;
  assign bus.o_state         = r_state;
  assign bus.o_instr_retired = w_retire;
  assign bus.o_instret       = r_instret;
  assign bus.o_trap          = r_trap;
  assign bus.o_trap_cause    = r_trap_cause;
endmodule

`default_nettype wire

// File: tb/tb_riscv_mc_control.sv
// ---------------------------------------------------------------------------
// tb_riscv_mc_control : vector table plus directed corner sequences. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_riscv_mc_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  riscv_mc_control_if #(.CNT_W(4)) bus ();

  riscv_mc_control #(.CNT_W(4), .TO_W(4), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0] op;
    logic       br;
    logic       rdy;
    logic [3:0] st;
    logic [4:0] en;   // {pc_write, ir_write, mem_read, mem_write, reg_write}
    logic [1:0] a, b, alu, m2r, pcs;
    logic       ret;
  } vec_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_J = 7'b1101111,
                         OP_JR = 7'b1100111;

  vec_t tbl [33];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(logic [6:0] op, logic br, logic rdy, logic [3:0] st,
                             logic [4:0] en, logic [1:0] a, logic [1:0] b,
                             logic [1:0] alu, logic [1:0] m2r, logic [1:0] pcs, logic ret);
    vec_t r;
    r.op = op; r.br = br; r.rdy = rdy; r.st = st; r.en = en;
    r.a = a; r.b = b; r.alu = alu; r.m2r = m2r; r.pcs = pcs; r.ret = ret;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [19:0] pack_act();
    return {bus.o_state, bus.o_pc_write, bus.o_ir_write, bus.o_mem_read, bus.o_mem_write,
            bus.o_reg_write, bus.o_alu_src_a, bus.o_alu_src_b, bus.o_alu_op,
            bus.o_mem_to_reg, bus.o_pc_src, bus.o_instr_retired};
  endfunction

  initial begin
    tbl[0]  = v(OP_R, 0, 1, 0,  5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[1]  = v(OP_R, 0, 1, 1,  5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[2]  = v(OP_R, 0, 1, 2,  5'b00000, 1, 0, 2, 0, 0, 0);
    tbl[3]  = v(OP_R, 0, 1, 7,  5'b00001, 0, 0, 0, 0, 0, 1);
    tbl[4]  = v(OP_L, 0, 1, 0,  5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[5]  = v(OP_L, 0, 1, 1,  5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[6]  = v(OP_L, 0, 1, 4,  5'b00000, 1, 2, 0, 0, 0, 0);
    tbl[7]  = v(OP_L, 0, 0, 5,  5'b00100, 0, 0, 0, 0, 0, 0);
    tbl[8]  = v(OP_L, 0, 0, 5,  5'b00100, 0, 0, 0, 0, 0, 0);
    tbl[9]  = v(OP_L, 0, 1, 5,  5'b00100, 0, 0, 0, 0, 0, 0);
    tbl[10] = v(OP_L, 0, 1, 8,  5'b00001, 0, 0, 0, 1, 0, 1);
    tbl[11] = v(OP_S, 0, 1, 0,  5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[12] = v(OP_S, 0, 1, 1,  5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[13] = v(OP_S, 0, 1, 4,  5'b00000, 1, 2, 0, 0, 0, 0);
    tbl[14] = v(OP_S, 0, 0, 6,  5'b00010, 0, 0, 0, 0, 0, 0);
    tbl[15] = v(OP_S, 0, 1, 6,  5'b00010, 0, 0, 0, 0, 0, 1);
    tbl[16] = v(OP_B, 0, 0, 0,  5'b00100, 0, 1, 0, 0, 0, 0);
    tbl[17] = v(OP_B, 0, 1, 0,  5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[18] = v(OP_B, 1, 1, 1,  5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[19] = v(OP_B, 1, 1, 9,  5'b10000, 1, 0, 1, 0, 1, 1);
    tbl[20] = v(OP_B, 0, 1, 0,  5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[21] = v(OP_B, 0, 1, 1,  5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[22] = v(OP_B, 0, 1, 9,  5'b00000, 1, 0, 1, 0, 1, 1);
    tbl[23] = v(OP_I, 0, 1, 0,  5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[24] = v(OP_I, 0, 1, 1,  5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[25] = v(OP_I, 0, 1, 3,  5'b00000, 1, 2, 3, 0, 0, 0);
    tbl[26] = v(OP_I, 0, 1, 7,  5'b00001, 0, 0, 0, 0, 0, 1);
    tbl[27] = v(OP_J, 0, 1, 0,  5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[28] = v(OP_J, 0, 1, 1,  5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[29] = v(OP_J, 0, 1, 10, 5'b10001, 0, 0, 0, 2, 1, 1);
    tbl[30] = v(OP_JR, 0, 1, 0, 5'b11100, 0, 1, 0, 0, 0, 0);
    tbl[31] = v(OP_JR, 0, 1, 1, 5'b00000, 2, 2, 0, 0, 0, 0);
    tbl[32] = v(OP_JR, 0, 1, 11, 5'b10001, 1, 2, 0, 2, 2, 1);

    // Reset state, with mem_ready high to show the write enables are masked.
    bus.i_opcode = OP_R; bus.i_branch_taken = 1'b0; bus.i_mem_ready = 1'b1;
    #2;
    chk("rst_state",    bus.o_state, 0);
    chk("rst_instret",  bus.o_instret, 0);
    chk("rst_trap",     {bus.o_trap, bus.o_trap_cause}, 0);
    chk("rst_wr_masks", {bus.o_pc_write, bus.o_ir_write, bus.o_reg_write, bus.o_mem_write}, 0);
    step(1);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 33; i++) begin
      bus.i_opcode = tbl[i].op; bus.i_branch_taken = tbl[i].br; bus.i_mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d", i), pack_act(),
          {tbl[i].st, tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].alu, tbl[i].m2r, tbl[i].pcs, tbl[i].ret});
      step(1);
    end
    chk("tbl_instret", bus.o_instret, 8);
    chk("tbl_no_trap", bus.o_trap, 0);

    // Memory timeout in FETCH: trap on the 4th wait cycle.
    do_reset();
    bus.i_mem_ready = 1'b0;
    step(3);
    chk("to_3_wait", {bus.o_state, bus.o_trap}, {4'd0, 1'b0});
    step(1);
    chk("to_state", bus.o_state, 15);
    chk("to_cause", {bus.o_trap, bus.o_trap_cause}, {1'b1, 2'b10});
    chk("to_outs_zero", {bus.o_mem_read, bus.o_pc_write, bus.o_ir_write}, 0);

    // mem_ready on the 4th cycle wins over the timeout.
    do_reset();
    bus.i_mem_ready = 1'b0;
    step(3);
    bus.i_mem_ready = 1'b1;
    step(1);
    chk("to_race_state", bus.o_state, 1);
    chk("to_race_trap", bus.o_trap, 0);

    // One JAL, then an illegal opcode: sticky trap, instret frozen.
    do_reset();
    bus.i_opcode = OP_J; bus.i_mem_ready = 1'b1;
    step(3);
    chk("ill_pre_instret", bus.o_instret, 1);
    bus.i_opcode = 7'b0000000;
    step(2);
    chk("ill_state", bus.o_state, 15);
    chk("ill_cause", {bus.o_trap, bus.o_trap_cause}, {1'b1, 2'b01});
    for (int k = 0; k < 4; k++) begin
      bus.i_mem_ready = k[0];
      bus.i_opcode = OP_R;
      step(1);
    end
    chk("ill_hold", {bus.o_state, bus.o_trap, bus.o_trap_cause}, {4'd15, 1'b1, 2'b01});
    chk("ill_instret", bus.o_instret, 1);

    // instret wrap with a 4-bit counter.
    do_reset();
    bus.i_opcode = OP_J; bus.i_mem_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step(2);
      if (i == 17) chk("wrap_retire_pulse", bus.o_instr_retired, 1);
      step(1);
      if (i == 15) chk("wrap_15", bus.o_instret, 15);
      if (i == 16) chk("wrap_0", bus.o_instret, 0);
      if (i == 17) chk("wrap_1", bus.o_instret, 1);
    end

    // Asynchronous reset while a store waits in MEM_WR.
    bus.i_opcode = OP_S;
    step(3);
    bus.i_mem_ready = 1'b0;
    #1;
    chk("mw_pre", {bus.o_state, bus.o_mem_write}, {4'd6, 1'b1});
    bus.i_mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("mw_rst_state", bus.o_state, 0);
    chk("mw_rst_outs", {bus.o_mem_write, bus.o_pc_write, bus.o_ir_write, bus.o_instr_retired}, 0);
    chk("mw_rst_instret", bus.o_instret, 0);
    step(1);
    reset = 1'b0;
    #1;
    chk("mw_post_instret", bus.o_instret, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
